matmul_operand_skewer: RTL and testbench

Parametrised successor to the matrix-multiply operand shifter. Latches operand matrices A (N×K) and B (K×M) on a start pulse, then streams diagonally skewed row/column vectors into the MAX_DIM×MAX_DIM systolic PE array, one wavefront per cycle. Adds downstream stall, an optional transposed-B mode, explicit valid/busy status and a single-cycle done pulse. Sits between the register-file matrix buffers and the PE array.

---
 rtl/matmul_operand_skewer_pkg.sv | 29 ++
 rtl/matmul_skew_lane.sv | 40 ++++
 rtl/matmul_operand_skewer.sv | 153 +++++++++++++++
 tb/tb_matmul_operand_skewer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_operand_skewer_pkg.sv
// Shared defaults, width helpers, FSM state type and flat-index helper for the
// matrix-multiply operand skewer.
package matmul_operand_skewer_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefBusWidth  = 32;
    localparam int unsigned DefMaxDim    = DefBusWidth / DefDataWidth;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDone
    } state_e;

    function automatic int unsigned dim_width(int unsigned max_dim);
        return $clog2(max_dim);
    endfunction

    // Must hold the wavefront count T, which peaks at 3*MAX_DIM-2.
    function automatic int unsigned cnt_width(int unsigned max_dim);
        return $clog2(3 * max_dim);
    endfunction

    function automatic int unsigned flat_idx(int unsigned r, int unsigned c,
                                             int unsigned max_dim);
        return r * max_dim + c;
    endfunction

endpackage

// File: rtl/matmul_skew_lane.sv
// One skew lane: selects element k = t - LANE of its latched row/column when the
// lane and k are inside the active job dimensions, otherwise drives zero.
module matmul_skew_lane
    import matmul_operand_skewer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned MAX_DIM    = DefMaxDim,
    parameter int unsigned DIM_W      = dim_width(MAX_DIM),
    parameter int unsigned CNT_W      = cnt_width(MAX_DIM),
    parameter int unsigned LANE       = 0
) (
    input  logic [CNT_W-1:0]              t_i,
    input  logic [DIM_W-1:0]              k_last_i,
    input  logic [DIM_W-1:0]              lane_last_i,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] vec_i,
    output logic [DATA_WIDTH-1:0]         elem_o
);

    localparam logic [CNT_W-1:0] LaneIdx  = CNT_W'(LANE);
    localparam logic [DIM_W-1:0] LaneDim  = DIM_W'(LANE);

    logic [CNT_W-1:0] k_idx;
    logic             in_range;

    always_comb begin
        // Unsigned subtraction may wrap; the t_i >= LaneIdx guard discards that case.
        k_idx    = t_i - LaneIdx;
        in_range = (LaneDim <= lane_last_i) && (t_i >= LaneIdx) &&
                   (k_idx <= CNT_W'(k_last_i));
        elem_o   = '0;
        if (in_range) begin
            for (int unsigned c = 0; c < MAX_DIM; c++) begin
                if (k_idx == CNT_W'(c)) begin
                    elem_o = vec_i[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/matmul_operand_skewer.sv
// Latches A and B on start and streams diagonally skewed wavefronts into the
// systolic PE array, with stall, transposed-B mode and busy/done status.
module matmul_operand_skewer
    import matmul_operand_skewer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned BUS_WIDTH  = DefBusWidth,
    parameter int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned DIM_W      = dim_width(MAX_DIM)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic                                  b_transposed_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] matrix_a_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] matrix_b_i,
    input  logic [DIM_W-1:0]                      n_i,
    input  logic [DIM_W-1:0]                      k_i,
    input  logic [DIM_W-1:0]                      m_i,
    input  logic                                  stall_i,
    output logic [MAX_DIM*DATA_WIDTH-1:0]         out_vector_a_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]         out_vector_b_o,
    output logic                                  valid_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int unsigned CNT_W = cnt_width(MAX_DIM);
    localparam int unsigned VEC_W = MAX_DIM * DATA_WIDTH;
    localparam int unsigned MAT_W = MAX_DIM * VEC_W;

    state_e           state_q;
    logic [MAT_W-1:0] a_q;
    logic [MAT_W-1:0] b_q;
    logic [MAT_W-1:0] b_cols_d;
    logic [DIM_W-1:0] n_q, k_q, m_q;
    logic [CNT_W-1:0] t_q;
    logic [CNT_W-1:0] t_last;
    logic [VEC_W-1:0] wave_a, wave_b;
    logic [VEC_W-1:0] vec_a_q, vec_b_q;
    logic             valid_q, busy_q, done_q;

    // B is stored column-major (column j contiguous) so both modes share one lane datapath.
    always_comb begin
        b_cols_d = '0;
        for (int unsigned j = 0; j < MAX_DIM; j++) begin
            for (int unsigned k = 0; k < MAX_DIM; k++) begin
                b_cols_d[flat_idx(j, k, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH] = b_transposed_i ?
                    matrix_b_i[flat_idx(j, k, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH] :
                    matrix_b_i[flat_idx(k, j, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Last wavefront index T-1 = (Kd+Nd+Md-2)-1 = n+k+m.
    assign t_last = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q);

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
        matmul_skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DIM    (MAX_DIM),
            .DIM_W      (DIM_W),
            .CNT_W      (CNT_W),
            .LANE       (i)
        ) u_lane_a (
            .t_i         (t_q),
            .k_last_i    (k_q),
            .lane_last_i (n_q),
            .vec_i       (a_q[i*VEC_W +: VEC_W]),
            .elem_o      (wave_a[i*DATA_WIDTH +: DATA_WIDTH])
        );

        matmul_skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DIM    (MAX_DIM),
            .DIM_W      (DIM_W),
            .CNT_W      (CNT_W),
            .LANE       (i)
        ) u_lane_b (
            .t_i         (t_q),
            .k_last_i    (k_q),
            .lane_last_i (m_q),
            .vec_i       (b_q[i*VEC_W +: VEC_W]),
            .elem_o      (wave_b[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            vec_a_q <= '0;
            vec_b_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        a_q     <= matrix_a_i;
                        b_q     <= b_cols_d;
                        n_q     <= n_i;
                        k_q     <= k_i;
                        m_q     <= m_i;
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StFeed;
                    end
                end
                StFeed: begin
                    if (t_q <= t_last) begin
                        // A stalled cycle holds the vectors and t; only valid drops.
                        if (!stall_i) begin
                            vec_a_q <= wave_a;
                            vec_b_q <= wave_b;
                            valid_q <= 1'b1;
                            t_q     <= t_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end else begin
                        vec_a_q <= '0;
                        vec_b_q <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_vector_a_o = vec_a_q;
    assign out_vector_b_o = vec_b_q;
    assign valid_o        = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_matmul_operand_skewer.sv
// Randomised self-checking bench: per-cycle DUT traces are compared against a
// wavefront model built from the skew formula and a cycle-level job timeline.
module tb_matmul_operand_skewer;

    localparam int DW = 8;
    localparam int MD = 4;
    localparam int L  = 40;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              b_transposed_i = 1'b0;
    logic [MD*MD*DW-1:0] matrix_a_i = '0;
    logic [MD*MD*DW-1:0] matrix_b_i = '0;
    logic [1:0]        n_i = '0, k_i = '0, m_i = '0;
    logic              stall_i = 1'b0;
    logic [MD*DW-1:0]  out_vector_a_o, out_vector_b_o;
    logic              valid_o, busy_o, done_o;

    matmul_operand_skewer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .b_transposed_i (b_transposed_i),
        .matrix_a_i     (matrix_a_i),
        .matrix_b_i     (matrix_b_i),
        .n_i            (n_i),
        .k_i            (k_i),
        .m_i            (m_i),
        .stall_i        (stall_i),
        .out_vector_a_o (out_vector_a_o),
        .out_vector_b_o (out_vector_b_o),
        .valid_o        (valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        b;
        logic        d;
        logic [31:0] va;
        logic [31:0] vb;
    } trace_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] am[MD][MD];
    logic [7:0] bm[MD][MD];  // logical B (K x M), independent of supply mode
    int         nd, kd, md;
    bit         trans;
    bit         stall_pat[L];
    bit         start_pat[L];
    trace_t     obs[L];
    trace_t     exp_t[L];
    trace_t     saved[L];

    function automatic logic [31:0] wave_a(int t);
        logic [31:0] r = '0;
        for (int i = 0; i < MD; i++) begin
            if (i < nd && t - i >= 0 && t - i < kd) r[i*8 +: 8] = am[i][t-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] wave_b(int t);
        logic [31:0] r = '0;
        for (int j = 0; j < MD; j++) begin
            if (j < md && t - j >= 0 && t - j < kd) r[j*8 +: 8] = bm[t-j][j];
        end
        return r;
    endfunction

    task automatic build_exp();
        int   issued = 0;
        int   total = nd + kd + md - 2;
        logic busy = 1'b1, done = 1'b0, v = 1'b0;
        logic [31:0] ca = '0, cb = '0;
        for (int c = 0; c < L; c++) begin
            exp_t[c].v = v; exp_t[c].b = busy; exp_t[c].d = done;
            exp_t[c].va = ca; exp_t[c].vb = cb;
            if (busy) begin
                if (issued < total) begin
                    if (!stall_pat[c]) begin
                        v = 1'b1; ca = wave_a(issued); cb = wave_b(issued); issued++;
                    end else begin
                        v = 1'b0;
                    end
                end else begin
                    v = 1'b0; ca = '0; cb = '0; busy = 1'b0; done = 1'b1;
                end
            end else if (done) begin
                done = 1'b0;
            end else if (start_pat[c]) begin
                busy = 1'b1; issued = 0;
            end
        end
    endtask

    task automatic drive_cfg();
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                matrix_a_i[(r*MD+c)*8 +: 8] = am[r][c];
                matrix_b_i[(r*MD+c)*8 +: 8] = trans ? bm[c][r] : bm[r][c];
            end
        end
        n_i = 2'(nd - 1); k_i = 2'(kd - 1); m_i = 2'(md - 1);
        b_transposed_i = trans;
    endtask

    // Issues a start from IDLE and records L cycles of outputs.
    task automatic run_job();
        @(negedge clk);
        drive_cfg();
        start_i = 1'b1;
        stall_i = 1'b0;
        for (int c = 0; c < L; c++) begin
            @(posedge clk);
            #1;
            obs[c].v = valid_o; obs[c].b = busy_o; obs[c].d = done_o;
            obs[c].va = out_vector_a_o; obs[c].vb = out_vector_b_o;
            start_i = start_pat[c];
            stall_i = stall_pat[c];
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        b_transposed_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic clear_pats();
        for (int c = 0; c < L; c++) begin
            stall_pat[c] = 1'b0;
            start_pat[c] = 1'b0;
        end
    endtask

    task automatic set_demo();
        logic [7:0] rows[MD][MD] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{8, 7, 6, 5}, '{4, 3, 2, 1}};
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                am[r][c] = rows[r][c];
                bm[r][c] = rows[r][c];
            end
        end
        nd = 4; kd = 4; md = 4; trans = 1'b0;
    endtask

    task automatic randomise_mats();
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                am[r][c] = 8'($urandom_range(1, 255));
                bm[r][c] = 8'($urandom_range(1, 255));
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_vector_a_o !== '0) begin
            errors++; $display("FAIL reset_vec_a got %h want 0", out_vector_a_o);
        end
        checks++;
        if (out_vector_b_o !== '0) begin
            errors++; $display("FAIL reset_vec_b got %h want 0", out_vector_b_o);
        end
        checks++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {valid_o, busy_o, done_o});
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        int nvalid = 0;
        int done_at = -1;
        set_demo(); clear_pats(); build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL directed c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
            if (obs[c].v) nvalid++;
            if (obs[c].d && done_at < 0) done_at = c;
        end
        checks++;
        if (nvalid != 10) begin errors++; $display("FAIL directed_count got %0d want 10", nvalid); end
        checks++;
        if (done_at != 11) begin errors++; $display("FAIL directed_done got %0d want 11", done_at); end
        checks++;
        if (obs[1].va !== 32'h00000001 || obs[1].vb !== 32'h00000001) begin
            errors++; $display("FAIL directed_t0 got %h %h want 1 1", obs[1].va, obs[1].vb);
        end
        for (int c = 0; c < L; c++) saved[c] = obs[c];
    endtask

    task automatic test_small();
        randomise_mats();
        nd = 1; kd = 1; md = 3; trans = 1'b0;
        clear_pats(); build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++; $display("FAIL small c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
        end
        checks++;
        if (obs[3].vb[31:24] !== 8'h00 || obs[3].va[31:8] !== '0) begin
            errors++; $display("FAIL small_lanes got %h %h", obs[3].va, obs[3].vb);
        end
    endtask

    task automatic test_stall();
        int done_at = -1;
        int k = 0;
        set_demo(); clear_pats();
        stall_pat[2] = 1'b1;  // suppresses the cycle that would carry t=2
        stall_pat[6] = 1'b1;  // and the one that would carry t=5
        build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++; $display("FAIL stall c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
            if (obs[c].d && done_at < 0) done_at = c;
        end
        checks++;
        if (done_at != 13) begin errors++; $display("FAIL stall_done got %0d want 13", done_at); end
        for (int c = 0; c < L; c++) begin
            if (obs[c].v) begin
                while (k < L && !saved[k].v) k++;
                checks++;
                if (k >= L || obs[c].va !== saved[k].va || obs[c].vb !== saved[k].vb) begin
                    errors++; $display("FAIL stall_seq c%0d got %h %h", c, obs[c].va, obs[c].vb);
                end
                k++;
            end
        end
    endtask

    task automatic test_transposed();
        set_demo(); trans = 1'b1;
        clear_pats(); build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== saved[c] || obs[c] !== exp_t[c]) begin
                errors++;
                $display("FAIL transposed c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
        end
    endtask

    task automatic test_start_ignored();
        set_demo(); clear_pats();
        start_pat[3] = 1'b1; start_pat[5] = 1'b1; start_pat[11] = 1'b1;
        build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++; $display("FAIL start_ignored c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        randomise_mats();
        nd = 1; kd = 1; md = 1; trans = 1'b0;
        clear_pats();
        for (int c = 0; c < L; c++) start_pat[c] = 1'b1;
        build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++; $display("FAIL back_to_back c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
        end
        checks++;
        if (obs[2].d !== 1'b1 || obs[3].b !== 1'b0 || obs[3].d !== 1'b0 || obs[4].b !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_gap got d2=%b b3=%b d3=%b b4=%b want 1 0 0 1",
                     obs[2].d, obs[3].b, obs[3].d, obs[4].b);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        set_demo(); clear_pats();
        @(negedge clk);
        drive_cfg();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);  // t=0..2 issued
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre got busy=%b valid=%b want 1 1", busy_o, valid_o);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({valid_o, busy_o, done_o, out_vector_a_o, out_vector_b_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got v%b b%b d%b %h %h want all 0",
                     valid_o, busy_o, done_o, out_vector_a_o, out_vector_b_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        build_exp(); run_job();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (obs[c] !== exp_t[c]) begin
                errors++; $display("FAIL reset_mid_rerun c%0d got %h want %h", c, obs[c], exp_t[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            randomise_mats();
            nd = $urandom_range(1, MD); kd = $urandom_range(1, MD); md = $urandom_range(1, MD);
            trans = 1'($urandom_range(0, 1));
            clear_pats();
            for (int c = 0; c < 24; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
            build_exp(); run_job();
            for (int c = 0; c < L; c++) begin
                checks++;
                if (obs[c] !== exp_t[c]) begin
                    errors++;
                    $display("FAIL random j%0d dims %0d/%0d/%0d c%0d got %h want %h",
                             j, nd, kd, md, c, obs[c], exp_t[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_small();
        test_stall();
        test_transposed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
